bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//  Round-robin arbiter for the shared system bus. DMA engines, the CPU and the camera each raise requestTransaction.
//  The arbiter drives a one-hot transactionGranted back to each of them.
//  It watches beginTransaction, endTransaction and busError on the bus to decide when the current owner has released it.
//  It sits between the bus masters and the bus; it never drives addressData itself.
// PARAMETERS
//  NUM_MASTERS     4    number of requesters (2..8); index 0 = highest tie-break priority after reset
//  TIMEOUT_CYCLES  1024 max cycles one grant may last before forced release (used only with BUS_ARB_TIMEOUT_EN)
// PORTS
//  clock               in   1            system clock, rising edge
//  reset               in   1            synchronous, active-high
//  request             in   NUM_MASTERS  requestTransaction from each master, level
//  beginTransactionIn  in   1            bus begin strobe (from granted master)
//  endTransactionIn    in   1            bus end strobe
//  busErrorIn          in   1            bus error from slave
//  grant               out  NUM_MASTERS  one-hot transactionGranted, registered
//  grantValid          out  1            |grant, registered
//  grantId             out  3            index of granted master, 0 when none
//  busErrorOut         out  1            1-cycle timeout error pulse (0 without macro)
// BEHAVIOUR
//  Reset: grant=0, grantValid=0, grantId=0, busErrorOut=0, state=IDLE, lastPtr=NUM_MASTERS-1 (so master 0 wins first).
//  FSM states IDLE, GRANTED, BUSY; all outputs registered.
//  IDLE: if request!=0, winner = first set bit scanning lastPtr+1, lastPtr+2, ... (mod NUM_MASTERS).
//    grant[winner]=1 at next edge; lastPtr<=winner; go to GRANTED. Latency request->grant = 1 cycle.
//  GRANTED: owner has the grant but has not started.
//    beginTransactionIn=1 -> BUSY.
//    request[owner] drops before begin -> grant cleared next edge -> IDLE (abandoned grant).
//  BUSY: grant held until endTransactionIn=1 or busErrorIn=1.
//    Then grant cleared at next edge -> IDLE. request[owner] is ignored in BUSY.
//  Mandatory 1-cycle bus-idle gap: after a release the arbiter spends >=1 cycle in IDLE with grant=0.
//    New grant no earlier than 2 cycles after the end strobe.
//  Simultaneous end + new requests: requests are evaluated in the IDLE cycle; owner just released is lowest priority.
//  beginTransactionIn / endTransactionIn while IDLE: ignored.
//  end and begin in the same cycle while GRANTED: treated as end -> IDLE.
//  Single requester holding request high: re-granted every time with the idle gap; no starvation of others.
//    Any waiting master is served within NUM_MASTERS grants.
//  Request bits >= NUM_MASTERS do not exist; grantId width is fixed at 3, upper bits 0.
//  Reset asserted mid-transaction: grant dropped at that edge, lastPtr reinitialised; no busErrorOut.
// CONFIGURATION
//  BUS_ARB_TIMEOUT_EN defined:
//    10-bit watchdog counter cleared on every new grant; increments each cycle in GRANTED/BUSY.
//    When it reaches TIMEOUT_CYCLES-1: busErrorOut=1 for exactly one cycle, grant cleared at the same edge, -> IDLE.
//    Real endTransactionIn in that same cycle wins: normal release, no error.
//  BUS_ARB_TIMEOUT_EN undefined: no counter, busErrorOut tied 0, grant held indefinitely.
// STRUCTURE
//  Shared package bus_arb_pkg: state encodings (IDLE=2'd0, GRANTED=2'd1, BUSY=2'd2), MAX_MASTERS=8, grantId width.
//  One sub-module: rr_priority_pick (combinational).
//    Inputs: request vector, lastPtr. Outputs: one-hot winner + index.
//    Implemented as a rotate / find-first / rotate-back.
//  Top holds the FSM, lastPtr register, output registers and optional watchdog.
// TESTING
//  1. After reset, request=4'b1111 -> grant=0001 next cycle, grantId=0.
//     begin, end 5 cycles later -> grant 0 one cycle, then 0010.
//  2. request=4'b1001, release each grant -> grant order 0001,1000,0001,1000.
//     Check the 1-cycle gap each time.
//  3. Grant to master 2, drop request[2] before begin -> grant=0 next cycle, state IDLE, no busErrorOut.
//  4. In BUSY, assert busErrorIn for 1 cycle -> grant cleared next edge.
//     Pending request[3] granted 1 cycle later.
//  5. With BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: begin, never end -> busErrorOut pulses once.
//     Grant drops 16 cycles after grant; without macro grant still held at cycle 100.
//  6. Assert reset while BUSY with master 1 -> grant=0 at that edge.
//     After reset, request=4'b0110 -> master 1 granted (pointer reinitialised).

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM encoding and widths.
package bus_arb_pkg;
  localparam int MAX_MASTERS = 8;
  localparam int GID_W       = 3;
  localparam int WDOG_W      = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate the request vector so the slot after
// last_ptr is at bit 0, find the first set bit, rotate the index back.
module rr_priority_pick
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0] request,
  input  logic [GID_W-1:0]       last_ptr,
  output logic [NUM_MASTERS-1:0] winner,
  output logic [GID_W-1:0]       win_idx,
  output logic                   win_valid
);
  logic [NUM_MASTERS-1:0] rotated;
  logic                   found;
  int                     offset;
  int                     idx;

  always_comb begin
    rotated = '0;
    found   = 1'b0;
    offset  = 0;
    for (int i = 0; i < NUM_MASTERS; i++)
      rotated[i] = request[(i + int'(last_ptr) + 1) % NUM_MASTERS];
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && rotated[i]) begin
        found  = 1'b1;
        offset = i;
      end
    end
    idx       = (int'(last_ptr) + 1 + offset) % NUM_MASTERS;
    winner    = '0;
    if (found) winner[idx] = 1'b1;
    win_idx   = found ? GID_W'(idx) : '0;
    win_valid = found;
  end
endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for the shared system bus; registered one-hot grant.
// Optional grant watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] request,
  input  logic                   beginTransactionIn,
  input  logic                   endTransactionIn,
  input  logic                   busErrorIn,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   grantValid,
  output logic [2:0]             grantId,
  output logic                   busErrorOut
);
  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << WDOG_W)) begin : g_bad_cfg
    $error("bus_rr_arbiter: unsupported NUM_MASTERS/TIMEOUT_CYCLES");
  end

  arb_state_e             state, state_n;
  logic [GID_W-1:0]       last_ptr, last_ptr_n;
  logic [NUM_MASTERS-1:0] grant_n;
  logic [2:0]             grant_id_n;
  logic                   bus_err_n;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [GID_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   owner_req;
  logic                   release_now;

  rr_priority_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .request  (request),
    .last_ptr (last_ptr),
    .winner   (pick_onehot),
    .win_idx  (pick_idx),
    .win_valid(pick_valid)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog;
  logic              wdog_hit;

  assign wdog_hit = (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  // Idle clears the count, so every new grant starts from zero.
  always_ff @(posedge clock) begin
    if (reset || state == IDLE) wdog <= '0;
    else                        wdog <= wdog + 1'b1;
  end
`endif

  assign owner_req   = |(request & grant);
  // Abandon only counts before begin; once BUSY the owner's request is ignored.
  assign release_now = endTransactionIn || busErrorIn ||
                       (state == GRANTED && !owner_req);

  always_comb begin
    state_n    = state;
    last_ptr_n = last_ptr;
    grant_n    = grant;
    grant_id_n = grantId;
    bus_err_n  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n    = GRANTED;
          grant_n    = pick_onehot;
          grant_id_n = pick_idx;
          last_ptr_n = pick_idx;
        end
      end
      GRANTED, BUSY: begin
        if (release_now) begin
          state_n    = IDLE;
          grant_n    = '0;
          grant_id_n = '0;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (wdog_hit) begin
          state_n    = IDLE;
          grant_n    = '0;
          grant_id_n = '0;
          bus_err_n  = 1'b1;
        end
`endif
        else if (state == GRANTED && beginTransactionIn) begin
          state_n = BUSY;
        end
      end
      default: begin
        state_n    = IDLE;
        grant_n    = '0;
        grant_id_n = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_ptr    <= GID_W'(NUM_MASTERS - 1);
      grant       <= '0;
      grantValid  <= 1'b0;
      grantId     <= '0;
      busErrorOut <= 1'b0;
    end else begin
      state       <= state_n;
      last_ptr    <= last_ptr_n;
      grant       <= grant_n;
      grantValid  <= |grant_n;
      grantId     <= grant_id_n;
      busErrorOut <= bus_err_n;
    end
  end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus random traffic, all checked
// against an ownership/round-robin model of the arbiter's rules.
module tb_bus_rr_arbiter;
  localparam int N = 4;
  localparam int T = 16;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] request;
  logic         begin_t, end_t, err_in;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [2:0]   grant_id;
  logic         bus_err;

  int vectors     = 0;
  int miscompares = 0;

  // Model: who owns the bus (-1 = nobody), whether it has begun, how long held.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_age   = 0;
  bit m_began = 1'b0;
  bit m_err   = 1'b0;

  always #5 clock = ~clock;

  bus_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
    .clock             (clock),
    .reset             (reset),
    .request           (request),
    .beginTransactionIn(begin_t),
    .endTransactionIn  (end_t),
    .busErrorIn        (err_in),
    .grant             (grant),
    .grantValid        (grant_valid),
    .grantId           (grant_id),
    .busErrorOut       (bus_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock; model decides from the inputs present before the edge.
  task automatic tick();
    int no = m_owner, nl = m_last, na = m_age;
    bit nb = m_began, ne = 1'b0, found = 1'b0;
    logic [N-1:0] eg;
    if (reset) begin
      no = -1; nl = N - 1; nb = 1'b0; na = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c = (m_last + k) % N;
        if (!found && request[c]) begin
          found = 1'b1; no = c; nl = c; nb = 1'b0; na = 0;
        end
      end
    end else if (end_t || err_in || (!m_began && !request[m_owner])) begin
      no = -1;
    end else if (TIMEOUT_ON && m_age == T - 1) begin
      no = -1; ne = 1'b1;
    end else begin
      if (begin_t) nb = 1'b1;
      na = m_age + 1;
    end
    @(posedge clock);
    #1;
    m_owner = no; m_last = nl; m_age = na; m_began = nb; m_err = ne;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check("model_grant", 32'(grant), 32'(eg));
    check("model_valid", 32'(grant_valid), 32'(m_owner >= 0));
    check("model_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("model_buserr", 32'(bus_err), 32'(m_err));
  endtask

  task automatic do_reset();
    reset = 1'b1; request = '0; begin_t = 1'b0; end_t = 1'b0; err_in = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; request = '0; begin_t = 1'b0; end_t = 1'b0; err_in = 1'b0;
    tick();
    tick();
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_id", 32'(grant_id), 32'd0);
    reset = 1'b0;

    // 1: all request, master 0 first, then master 1 after the idle gap
    request = 4'b1111;
    tick();
    check("t1_first", 32'(grant), 32'b0001);
    check("t1_id0", 32'(grant_id), 32'd0);
    begin_t = 1'b1; tick(); begin_t = 1'b0;
    repeat (4) tick();
    end_t = 1'b1; tick(); end_t = 1'b0;
    check("t1_gap", 32'(grant), 32'd0);
    tick();
    check("t1_second", 32'(grant), 32'b0010);
    check("t1_id1", 32'(grant_id), 32'd1);

    // 2: two requesters alternate, with a gap each time
    do_reset();
    request = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      logic [N-1:0] want;
      want = (i % 2 == 0) ? 4'b0001 : 4'b1000;
      tick();
      check("t2_order", 32'(grant), 32'(want));
      end_t = 1'b1; tick(); end_t = 1'b0;
      check("t2_gap", 32'(grant), 32'd0);
    end

    // 3: abandoned grant
    do_reset();
    request = 4'b0100;
    tick();
    check("t3_grant", 32'(grant), 32'b0100);
    request = 4'b0000;
    tick();
    check("t3_drop", 32'(grant), 32'd0);
    check("t3_noerr", 32'(bus_err), 32'd0);

    // 4: bus error ends a busy transfer, pending master served next
    do_reset();
    request = 4'b0010;
    tick();
    begin_t = 1'b1; tick(); begin_t = 1'b0;
    request = 4'b1000;
    err_in = 1'b1; tick(); err_in = 1'b0;
    check("t4_clear", 32'(grant), 32'd0);
    tick();
    check("t4_next", 32'(grant), 32'b1000);

    // 5: watchdog (or indefinite hold without it)
    do_reset();
    request = 4'b0001;
    tick();
    begin_t = 1'b1; tick(); begin_t = 1'b0;
    if (TIMEOUT_ON) begin
      repeat (T - 2) tick();
      check("t5_held", 32'(grant), 32'b0001);
      request = 4'b0000;
      tick();
      check("t5_drop", 32'(grant), 32'd0);
      check("t5_pulse", 32'(bus_err), 32'd1);
      tick();
      check("t5_pulse_end", 32'(bus_err), 32'd0);
    end else begin
      repeat (100) tick();
      check("t5_hold", 32'(grant), 32'b0001);
      check("t5_noerr", 32'(bus_err), 32'd0);
    end

    // 6: reset mid-transaction re-seeds the pointer
    do_reset();
    request = 4'b0010;
    tick();
    begin_t = 1'b1; tick(); begin_t = 1'b0;
    check("t6_busy", 32'(grant), 32'b0010);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_err", 32'(bus_err), 32'd0);
    request = 4'b0110;
    tick();
    check("t6_regrant", 32'(grant), 32'b0010);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) request = N'($urandom);
      begin_t = ($urandom_range(2) == 0);
      end_t   = ($urandom_range(7) == 0);
      err_in  = ($urandom_range(31) == 0);
      reset   = ($urandom_range(299) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
